// File: rtl/pads_cfg_loader.sv
// Purpose : walks every pad-config register over Wishbone, writing each pad's OEN bit.
// Latency : 3 cycles per pad with a zero-wait registered-ack slave; done pulses one cycle after the last GAP.
// Backpres: stalls in REQ/RD for wbm_ack_i up to TIMEOUT cycles, then aborts with err/err_idx set.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock; asynchronous active-high reset
//   start, cfg_oen              one-cycle request; per-pad OEN (1 = input) captured at start
//   wbm_*                       Wishbone master (classic cycles, one register per pad)
//   busy, done, err, err_idx    status: busy outside IDLE, done pulse, sticky error and first failing pad
//
// Build option: define PADS_CFG_VERIFY_EN to add a read-back pass (RD/RGAP) after the write pass.
module pads_cfg_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_6000,
    parameter int          NUM_PADS  = 38,
    parameter int          TIMEOUT   = 15
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    input  logic [NUM_PADS-1:0] cfg_oen,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [3:0]          wbm_sel_o,
    output logic [31:0]         wbm_adr_o,
    output logic [31:0]         wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [31:0]         wbm_dat_i,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [5:0]          err_idx
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        GAP  = 3'd2,
        RD   = 3'd3,
        RGAP = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [5:0]          idx;
    logic [7:0]          wait_cnt;
    logic [NUM_PADS-1:0] shadow;

    logic last_pad;
    logic expired;
    logic in_xfer;
    logic pad_bit;

    assign last_pad = (idx == 6'(NUM_PADS - 1));
    // The counter is about to reach TIMEOUT on this cycle; an ack in the
    // same cycle still completes the transfer.
    assign expired  = (wait_cnt == 8'(TIMEOUT - 1));
    assign in_xfer  = (state == REQ) || (state == RD);
    assign pad_bit  = shadow[idx];

    // Only bit 0 of read data carries pad state; the rest is ignored.
    logic unused_rd_bits;
    assign unused_rd_bits = ^wbm_dat_i;

`ifdef PADS_CFG_VERIFY_EN
    logic rd_bad;
    assign rd_bad = wbm_ack_i && (wbm_dat_i[0] != pad_bit);
`endif

    // ---------------------------------------------------------------- state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = REQ;
            end
            REQ: begin
                if (wbm_ack_i)    state_nxt = GAP;
                else if (expired) state_nxt = FIN;
            end
            GAP: begin
                // The idle cycle lets a registered ack drop before the next strobe.
                if (!last_pad) begin
                    state_nxt = REQ;
                end else begin
`ifdef PADS_CFG_VERIFY_EN
                    state_nxt = RD;
`else
                    state_nxt = FIN;
`endif
                end
            end
`ifdef PADS_CFG_VERIFY_EN
            RD: begin
                if (wbm_ack_i)    state_nxt = rd_bad ? FIN : RGAP;
                else if (expired) state_nxt = FIN;
            end
            RGAP: begin
                state_nxt = last_pad ? FIN : RD;
            end
`endif
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx      <= '0;
            wait_cnt <= '0;
            shadow   <= '0;
            err      <= 1'b0;
            err_idx  <= '0;
        end else begin
            // Zero outside REQ/RD, so every entry into REQ/RD starts from 0.
            if (in_xfer && !wbm_ack_i) wait_cnt <= wait_cnt + 8'd1;
            else                       wait_cnt <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        shadow  <= cfg_oen;
                        err     <= 1'b0;
                        err_idx <= '0;
                        idx     <= '0;
                    end
                end
                REQ: begin
                    if (!wbm_ack_i && expired) begin
                        err     <= 1'b1;
                        err_idx <= idx;
                    end
                end
                GAP: begin
                    if (!last_pad) idx <= idx + 6'd1;
`ifdef PADS_CFG_VERIFY_EN
                    else           idx <= '0;
`endif
                end
`ifdef PADS_CFG_VERIFY_EN
                RD: begin
                    if (rd_bad || (!wbm_ack_i && expired)) begin
                        err     <= 1'b1;
                        err_idx <= idx;
                    end
                end
                RGAP: begin
                    if (!last_pad) idx <= idx + 6'd1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = 4'h0;
        wbm_adr_o = 32'h0;
        wbm_dat_o = 32'h0;
        busy      = (state != IDLE);
        done      = (state == FIN);
        case (state)
            REQ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_sel_o = 4'hF;
                wbm_adr_o = BASE_ADDR + 32'(idx);
                wbm_dat_o = {31'b0, pad_bit};
            end
`ifdef PADS_CFG_VERIFY_EN
            RD: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_sel_o = 4'hF;
                wbm_adr_o = BASE_ADDR + 32'(idx);
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pads_cfg_loader.sv
// Bench for pads_cfg_loader: directed passes against a registered-ack Wishbone slave,
// expected bus transactions and done pulses queued at stimulus time and checked by a
// negedge monitor.
module tb_pads_cfg_loader;

    localparam logic [31:0] BASE = 32'h3000_6000;
`ifdef PADS_CFG_VERIFY_EN
    localparam int PASS = 229;
    localparam int NRD  = 38;
`else
    localparam int PASS = 115;
    localparam int NRD  = 0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start;
    logic [37:0] cfg_oen;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy, done, err;
    logic [5:0]  err_idx;

    pads_cfg_loader dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .start     (start),
        .cfg_oen   (cfg_oen),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_idx   (err_idx)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cycle = 0;
    always @(posedge wb_clk_i) cycle <= cycle + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_xact  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------------------------------------------------------- scoreboard queues
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic        dat;
    } xact_t;

    typedef struct {
        int         at;
        logic       err;
        logic [5:0] idx;
    } done_t;

    xact_t exp_q[$];
    done_t done_q[$];

    task automatic push_pass(input logic [37:0] cfg, input int nwr, input int nrd);
        xact_t x;
        for (int i = 0; i < nwr; i++) begin
            x.we = 1'b1; x.adr = BASE + 32'(i); x.dat = cfg[i];
            exp_q.push_back(x);
        end
        for (int i = 0; i < nrd; i++) begin
            x.we = 1'b0; x.adr = BASE + 32'(i); x.dat = 1'b0;
            exp_q.push_back(x);
        end
    endtask

    task automatic push_done(input int at, input logic e, input logic [5:0] ei);
        done_t d;
        d.at = at; d.err = e; d.idx = ei;
        done_q.push_back(d);
    endtask

    // ---------------------------------------------------------------- registered-ack slave
    logic [37:0] cur_cfg  = '0;
    int          withhold = -1;
    int          slow_pad = -1;
    int          slow_ws  = 0;
    int          flip_pad = -1;
    int          scnt;

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= '0;
            scnt      <= 0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            int p;
            p = int'(wbm_adr_o - BASE);
            scnt      <= scnt + 1;
            wbm_ack_i <= (p != withhold) && (scnt >= ((p == slow_pad) ? slow_ws : 0));
            wbm_dat_i <= {31'b0, cur_cfg[p[5:0]] ^ (p == flip_pad)};
        end else begin
            wbm_ack_i <= 1'b0;
            scnt      <= 0;
        end
    end

    // ---------------------------------------------------------------- monitor
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                n_xact++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_xact_adr", wbm_adr_o, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    xact_t e;
                    e = exp_q.pop_front();
                    chk("xact_we",  wbm_we_o,  e.we);
                    chk("xact_adr", wbm_adr_o, e.adr);
                    chk("xact_sel", wbm_sel_o, 4'hF);
                    if (e.we) chk("xact_dat", wbm_dat_o, {31'b0, e.dat});
                end
            end
            if (!wbm_cyc_o) chk("idle_bus_zero", |{wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_stb_o}, 0);
            if (done) begin
                n_done++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done_cycle", cycle, 0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", cycle, d.at);
                    chk("done_err",   err,   d.err);
                    chk("done_idx",   err_idx, d.idx);
                    chk("done_busy",  busy,  1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic launch(input logic [37:0] cfg, input int hold);
        cur_cfg = cfg;
        cfg_oen = cfg;
        start   = 1'b1;
        repeat (hold) @(negedge wb_clk_i);
        start   = 1'b0;
    endtask

    task automatic wait_pass(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(negedge wb_clk_i);
            k++;
        end
        @(negedge wb_clk_i);
        chk("pass_done_count", n_done, target);
        chk("sb_xact_empty", exp_q.size(), 0);
        chk("sb_done_empty", done_q.size(), 0);
        chk("idle_after_pass", busy, 0);
    endtask

    initial begin
        int k;
        int xs;
        wb_rst_i = 1'b1;
        start    = 1'b0;
        cfg_oen  = '0;
        repeat (3) @(negedge wb_clk_i);

        chk("reset_outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy, done, err, err_idx}, 0);
        chk("reset_bus", {wbm_adr_o, wbm_dat_o}, 0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // All pads input, zero-wait slave.
        push_pass(38'h3F_FFFF_FFFF, 38, NRD);
        push_done(cycle + PASS, 1'b0, 6'd0);
        launch(38'h3F_FFFF_FFFF, 1);
        wait_pass(1, 400);

        // All pads output, slave never answers pad 5: pads 0..4 written, abort.
        withhold = 5;
        push_pass(38'h00_0000_0000, 5, 0);
        push_done(cycle + 16 + 15, 1'b1, 6'd5);
        launch(38'h00_0000_0000, 1);
        wait_pass(2, 100);
        withhold = -1;
        repeat (5) @(negedge wb_clk_i);
        chk("err_held", {err, err_idx}, {1'b1, 6'd5});

        // Reset mid-pass at pad 10, then restart immediately after release.
        push_pass(38'h15_5555_5555, 10, 0);
        launch(38'h15_5555_5555, 1);
        chk("err_cleared_on_start", {err, err_idx}, 0);
        k = 0;
        while (!(wbm_cyc_o && wbm_adr_o == BASE + 32'd10) && k < 100) begin
            @(negedge wb_clk_i);
            k++;
        end
        chk("reached_pad10", wbm_adr_o, BASE + 32'd10);
        wb_rst_i = 1'b1;
        #1;
        chk("rst_async_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_sb_empty", exp_q.size(), 0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        push_pass(38'h2A_AAAA_AAAA, 38, NRD);
        push_done(cycle + PASS, 1'b0, 6'd0);
        launch(38'h2A_AAAA_AAAA, 1);
        chk("restart_adr", wbm_adr_o, BASE);
        wait_pass(3, 400);

        // Start held for 5 cycles: one pass, one done.
        push_pass(38'h01_2345_6789, 38, NRD);
        push_done(cycle + PASS, 1'b0, 6'd0);
        launch(38'h01_2345_6789, 5);
        wait_pass(4, 400);
        repeat (30) @(negedge wb_clk_i);
        chk("single_pass_done", n_done, 4);
        chk("single_pass_idle", busy, 0);

        // Pad 20 acks on the last allowed wait cycle: ack beats timeout.
        slow_pad = 20;
        slow_ws  = 13;
        push_pass(38'h3F_0000_FFFF, 38, NRD);
        push_done(cycle + PASS + 13, 1'b0, 6'd0);
        launch(38'h3F_0000_FFFF, 1);
        wait_pass(5, 400);
        slow_pad = -1;

`ifdef PADS_CFG_VERIFY_EN
        // Full write + read-back, all matching.
        xs = n_xact;
        push_pass(38'h2B_C0DE_1234, 38, 38);
        push_done(cycle + 229, 1'b0, 6'd0);
        launch(38'h2B_C0DE_1234, 1);
        wait_pass(6, 400);
        chk("verify_xact_count", n_xact - xs, 76);

        // Read-back of pad 36 returns 0 while written 1.
        flip_pad = 36;
        push_pass(38'h10_0000_0000, 38, 37);
        push_done(cycle + 225, 1'b1, 6'd36);
        launch(38'h10_0000_0000, 1);
        wait_pass(7, 400);
        flip_pad = -1;
`else
        xs = n_xact;
        repeat (2) @(negedge wb_clk_i);
        chk("no_stray_xact", n_xact - xs, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pads_cfg_loader.md
PADS_CFG_LOADER -- requirements
Module: pads_cfg_loader

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h3000_6000: pad-config register window base.
REQ-002 SHALL provide parameter NUM_PADS, default 38: number of pads programmed, one register each.
REQ-003 SHALL provide parameter TIMEOUT, default 15: maximum cycles to wait for wbm_ack_i per transaction (1..255).
REQ-004 SHALL have port wb_clk_i, input, 1: the only clock.
REQ-005 SHALL have port wb_rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1: one-cycle request to program all pads.
REQ-007 SHALL have port cfg_oen, input, NUM_PADS: desired OEN per pad (1 = input, 0 = output), captured at start.
REQ-008 SHALL have Wishbone master outputs wbm_cyc_o, wbm_stb_o, wbm_we_o (1 bit each), wbm_sel_o (4), wbm_adr_o (32) and wbm_dat_o (32).
REQ-009 SHALL have Wishbone master inputs wbm_ack_i (1) and wbm_dat_i (32).
REQ-010 SHALL have outputs busy (1), done (1, pulse), err (1, sticky) and err_idx (6): index of the first failing pad.

Function
REQ-011 SHALL use FSM states IDLE, REQ, GAP, RD, RGAP and FIN.
REQ-012 SHALL, in IDLE with start=1, capture cfg_oen into a shadow register, clear err, err_idx and the pad index, and enter REQ on the next edge.
REQ-013 SHALL ignore start in any state other than IDLE.
REQ-014 SHALL, in REQ, drive wbm_cyc_o=wbm_stb_o=wbm_we_o=1, wbm_sel_o=4'hF, wbm_adr_o=BASE_ADDR+idx and wbm_dat_o={31'b0, shadow[idx]}.
REQ-015 SHALL, when wbm_ack_i=1 is sampled in REQ, enter GAP.
REQ-016 SHALL, in GAP, drive cyc, stb and we to 0 for exactly one cycle, then increment idx and return to REQ, or leave the write phase after idx=NUM_PADS-1.
REQ-017 SHALL enforce the one-cycle GAP so that a registered slave ack cannot be double-counted.
REQ-018 SHALL reset the wait counter on entry to REQ or RD and increment it every cycle without ack.
REQ-019 SHALL, when the wait counter reaches TIMEOUT with no ack, deassert cyc/stb, set err=1, load err_idx=idx and go to FIN.
REQ-020 SHALL let ack win if ack and timeout occur in the same cycle.
REQ-021 SHALL, in FIN, pulse done=1 for one cycle and return to IDLE.
REQ-022 SHALL keep busy=1 in every state except IDLE.
REQ-023 SHALL hold err and err_idx until the next accepted start.
REQ-024 SHALL drive wbm_adr_o, wbm_dat_o and wbm_sel_o to 0 whenever wbm_cyc_o=0.
REQ-025 SHALL take 3 cycles per pad with a zero-wait registered-ack slave: REQ, ack seen on the 2nd REQ cycle, GAP.

Reset
REQ-026 SHALL, on wb_rst_i=1 (async assert), force state=IDLE and all outputs, idx, counter and shadow to 0, including mid-transaction.
REQ-027 SHALL release reset synchronously with wb_clk_i, with the first start accepted on the first edge after release.

Configuration
REQ-028 SHALL, with PADS_CFG_VERIFY_EN defined, go to RD after the last GAP instead of FIN.
REQ-029 SHALL, in RD, issue reads (we=0, same address and sel rules) for idx 0..NUM_PADS-1, each followed by one RGAP cycle.
REQ-030 SHALL, in RD, compare wbm_dat_i[0] to shadow[idx] on ack, and on mismatch set err=1, err_idx=idx and go to FIN.
REQ-031 SHALL apply the same timeout rules in RD as in REQ.
REQ-032 SHALL, without PADS_CFG_VERIFY_EN, have no RD/RGAP logic, go from the last GAP directly to FIN, and never issue a read.

Verification
REQ-033 SHALL cover: cfg_oen=38'h3F_FFFF_FFFF, start, zero-wait slave -> 38 writes to 0x30006000..0x30006025 with dat=1, done at cycle 115, err=0.
REQ-034 SHALL cover: cfg_oen=38'h00_0000_0000, slave withholds ack only at 0x30006005 -> err=1, err_idx=5, done 15 cycles after that REQ started, no write to 0x30006006.
REQ-035 SHALL cover: wb_rst_i pulsed while idx=10 in REQ -> cyc=stb=0 and busy=0 immediately; a new start restarts at 0x30006000.
REQ-036 SHALL cover: start held high for 5 cycles during busy -> exactly one programming pass and one done pulse.
REQ-037 SHALL cover: with PADS_CFG_VERIFY_EN, slave returns bit0=0 on readback of 0x30006024 while cfg_oen[36]=1 -> err=1, err_idx=36.
REQ-038 SHALL cover: with PADS_CFG_VERIFY_EN, an all-matching slave -> 76 transactions, err=0, one done pulse.
